// File: rtl/reg_file_sb_if.sv
// Register-file bus: read ports, two write ports, and the issue/scoreboard handshake.
// The slave modport is the register file; the master modport is the pipeline side.
interface reg_file_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) ();
  logic [AW-1:0]    ra1, ra2;
  logic [XLEN-1:0]  rd1, rd2;
  logic             we_a, we_b;
  logic [AW-1:0]    wa_a, wa_b;
  logic [XLEN-1:0]  wd_a, wd_b;
  logic             iss_req;
  logic [AW-1:0]    iss_rd;
  logic             stall;
  logic [NREGS-1:0] busy_vec;
  logic [AW:0]      pend_cnt;

  modport slave (
    input  ra1, ra2, we_a, wa_a, wd_a, we_b, wa_b, wd_b, iss_req, iss_rd,
    output rd1, rd2, stall, busy_vec, pend_cnt
  );
  modport master (
    output ra1, ra2, we_a, wa_a, wd_a, we_b, wa_b, wd_b, iss_req, iss_rd,
    input  rd1, rd2, stall, busy_vec, pend_cnt
  );
endinterface

// File: rtl/reg_file_sb.sv
// Two-write-port integer register file with a busy scoreboard for long-latency writebacks.
// Optional RF_BYPASS_EN: same-cycle write forwarding on reads and same-cycle stall release.
module reg_file_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic         clk,
  input  logic         areset,
  reg_file_sb_if.slave bus
);

  logic [NREGS-1:1][XLEN-1:0] regs_q, regs_d;
  logic [NREGS-1:0]           busy_q, busy_d, eff_busy;
  logic [AW:0]                pend_q, pend_d;
  logic                       set_hit, clr_hit, stall;
  logic                       inc, dec;
  logic [XLEN-1:0]            rd1, rd2;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && ({1'b0, a} < (AW+1)'(NREGS));
  endfunction

  // Loop-based lookups keep out-of-range addresses reading as 0.
  function automatic logic [XLEN-1:0] stored(input logic [NREGS-1:1][XLEN-1:0] rf,
                                             input logic [AW-1:0] a);
    logic [XLEN-1:0] v;
    v = '0;
    for (int r = 1; r < NREGS; r++) if (a == AW'(r)) v = rf[r];
    return v;
  endfunction

  function automatic logic bit_at(input logic [NREGS-1:0] vec, input logic [AW-1:0] a);
    logic v;
    v = 1'b0;
    for (int r = 1; r < NREGS; r++) if (a == AW'(r)) v = vec[r];
    return v;
  endfunction

  assign clr_hit = bus.we_b && (bus.wa_b != '0);

`ifdef RF_BYPASS_EN
  // A writeback landing this cycle already releases its register.
  always_comb begin
    eff_busy = busy_q;
    for (int r = 1; r < NREGS; r++)
      if (clr_hit && bus.wa_b == AW'(r)) eff_busy[r] = 1'b0;
  end

  function automatic logic [XLEN-1:0] fwd(input logic [AW-1:0] a, input logic [XLEN-1:0] s);
    logic [XLEN-1:0] v;
    v = s;
    if (addr_ok(a)) begin
      if (bus.we_a && bus.wa_a == a)      v = bus.wd_a;
      else if (bus.we_b && bus.wa_b == a) v = bus.wd_b;
    end
    return v;
  endfunction

  always_comb begin
    rd1 = fwd(bus.ra1, stored(regs_q, bus.ra1));
    rd2 = fwd(bus.ra2, stored(regs_q, bus.ra2));
  end
`else
  assign eff_busy = busy_q;

  always_comb begin
    rd1 = stored(regs_q, bus.ra1);
    rd2 = stored(regs_q, bus.ra2);
  end
`endif

  // iss_rd term catches WAW so a busy destination is never re-issued.
  assign stall = areset && bus.iss_req &&
                 (bit_at(eff_busy, bus.ra1) || bit_at(eff_busy, bus.ra2) ||
                  bit_at(eff_busy, bus.iss_rd));
  assign set_hit = bus.iss_req && !stall && (bus.iss_rd != '0);

  always_comb begin
    regs_d = regs_q;
    for (int r = 1; r < NREGS; r++) begin
      if (bus.we_a && bus.wa_a == AW'(r))      regs_d[r] = bus.wd_a;
      else if (bus.we_b && bus.wa_b == AW'(r)) regs_d[r] = bus.wd_b;
    end
  end

  // Set beats clear on the same register: the issuing instruction is the younger owner.
  always_comb begin
    busy_d = '0;
    for (int r = 1; r < NREGS; r++)
      busy_d[r] = (set_hit && bus.iss_rd == AW'(r)) ||
                  (busy_q[r] && !(clr_hit && bus.wa_b == AW'(r)));
  end

  always_comb begin
    inc    = set_hit && addr_ok(bus.iss_rd) && !bit_at(busy_q, bus.iss_rd);
    dec    = clr_hit && bit_at(busy_q, bus.wa_b) && !(set_hit && bus.iss_rd == bus.wa_b);
    pend_d = pend_q + (AW+1)'(inc) - (AW+1)'(dec);
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      regs_q <= '0;
      busy_q <= '0;
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      pend_q <= pend_d;
    end
  end

  assign bus.rd1      = rd1;
  assign bus.rd2      = rd2;
  assign bus.stall    = stall;
  assign bus.busy_vec = busy_q;
  assign bus.pend_cnt = pend_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a 32-entry instance checked every cycle against a behavioural
// model, plus a 16-entry instance driven with directed vectors.
module tb_reg_file_sb;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic areset, areset16;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  reg_file_sb_if #(.XLEN(32), .NREGS(32)) b32 ();
  reg_file_sb_if #(.XLEN(32), .NREGS(16)) b16 ();

  reg_file_sb #(.XLEN(32), .NREGS(32)) u32 (.clk(clk), .areset(areset),   .bus(b32));
  reg_file_sb #(.XLEN(32), .NREGS(16)) u16 (.clk(clk), .areset(areset16), .bus(b16));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model of the 32-entry instance ----------------
  logic [31:0] m_reg  [32];
  bit          m_busy [32];

  function automatic bit eb(input int a);
    if (a == 0) return 1'b0;
    if (BYP && b32.we_b && int'(b32.wa_b) == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [31:0] exp_rd(input int a);
    if (a == 0) return 32'h0;
    if (BYP && b32.we_a && int'(b32.wa_a) == a) return b32.wd_a;
    if (BYP && b32.we_b && int'(b32.wa_b) == a) return b32.wd_b;
    return m_reg[a];
  endfunction

  always @(negedge clk) begin
    logic [31:0] bv;
    int          cnt;
    bit          st;
    bv  = '0;
    cnt = 0;
    if (!areset) begin
      for (int i = 0; i < 32; i++) begin
        m_reg[i]  = 32'h0;
        m_busy[i] = 1'b0;
      end
      chk("m_rst_busy", b32.busy_vec, 0);
      chk("m_rst_pend", b32.pend_cnt, 0);
      chk("m_rst_stall", b32.stall, 0);
    end else begin
      for (int i = 0; i < 32; i++) begin
        bv[i] = m_busy[i];
        if (m_busy[i]) cnt++;
      end
      st = b32.iss_req && (eb(int'(b32.ra1)) || eb(int'(b32.ra2)) || eb(int'(b32.iss_rd)));
      chk("m_rd1", b32.rd1, exp_rd(int'(b32.ra1)));
      chk("m_rd2", b32.rd2, exp_rd(int'(b32.ra2)));
      chk("m_stall", b32.stall, st);
      chk("m_busy", b32.busy_vec, bv);
      chk("m_pend", b32.pend_cnt, cnt);
      // state the coming edge must produce
      if (b32.we_b && b32.wa_b != 0) m_reg[b32.wa_b] = b32.wd_b;
      if (b32.we_a && b32.wa_a != 0) m_reg[b32.wa_a] = b32.wd_a;
      if (b32.we_b && b32.wa_b != 0) m_busy[b32.wa_b] = 1'b0;
      if (b32.iss_req && !st && b32.iss_rd != 0) m_busy[b32.iss_rd] = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle32();
    b32.ra1 = '0; b32.ra2 = '0;
    b32.we_a = 0; b32.wa_a = '0; b32.wd_a = '0;
    b32.we_b = 0; b32.wa_b = '0; b32.wd_b = '0;
    b32.iss_req = 0; b32.iss_rd = '0;
  endtask

  task automatic idle16();
    b16.ra1 = '0; b16.ra2 = '0;
    b16.we_a = 0; b16.wa_a = '0; b16.wd_a = '0;
    b16.we_b = 0; b16.wa_b = '0; b16.wd_b = '0;
    b16.iss_req = 0; b16.iss_rd = '0;
  endtask

  initial begin
    idle32();
    idle16();
    areset = 0;
    areset16 = 0;
    // stall must stay low in reset even with a request presented
    b32.iss_req = 1; b32.iss_rd = 5'd5; b32.ra1 = 5'd5;
    #2;
    chk("rst_stall", b32.stall, 0);
    chk("rst_busy", b32.busy_vec, 0);
    chk("rst_pend", b32.pend_cnt, 0);
    step(); step();
    areset = 1; areset16 = 1;
    idle32();

    // every address reads 0 after reset
    for (int i = 0; i < 32; i++) begin
      step();
      b32.ra1 = 5'(i); b32.ra2 = 5'(31 - i);
      #1;
      chk("rd_all1", b32.rd1, 0);
      chk("rd_all2", b32.rd2, 0);
    end

    // x0 writes dropped on both ports
    step(); idle32();
    b32.we_a = 1; b32.wd_a = 32'hDEADBEEF;
    b32.we_b = 1; b32.wd_b = 32'hDEADBEEF;
    #1 chk("x0_same", b32.rd1, 0);
    step(); idle32();
    #1 chk("x0_next", b32.rd1, 0);

    // same address on both ports: A wins
    step(); idle32();
    b32.we_a = 1; b32.wa_a = 5'd5; b32.wd_a = 32'h11;
    b32.we_b = 1; b32.wa_b = 5'd5; b32.wd_b = 32'h22;
    step(); idle32(); b32.ra1 = 5'd5;
    #1 chk("x5_a_wins", b32.rd1, 32'h11);

    // scoreboard set, RAW stall, release on writeback
    step(); idle32(); b32.iss_req = 1; b32.iss_rd = 5'd7;
    #1 chk("iss7_nostall", b32.stall, 0);
    step(); idle32(); b32.iss_req = 1; b32.ra1 = 5'd7;
    #1;
    chk("busy7", b32.busy_vec[7], 1);
    chk("pend1", b32.pend_cnt, 1);
    chk("raw7_stall", b32.stall, 1);
    step(); b32.we_b = 1; b32.wa_b = 5'd7; b32.wd_b = 32'h77;
    #1;
`ifdef RF_BYPASS_EN
    chk("wb7_byp_stall", b32.stall, 0);
    chk("wb7_byp_rd1", b32.rd1, 32'h77);
`else
    chk("wb7_stall", b32.stall, 1);
`endif
    step(); b32.we_b = 0;
    #1;
    chk("wb7_after_stall", b32.stall, 0);
    chk("wb7_after_rd1", b32.rd1, 32'h77);
    chk("wb7_after_pend", b32.pend_cnt, 0);

    // set and clear of x9 in one cycle
    step(); idle32(); b32.iss_req = 1; b32.iss_rd = 5'd9;
    step(); b32.we_b = 1; b32.wa_b = 5'd9; b32.wd_b = 32'h99;
    step(); idle32();
    #1;
`ifdef RF_BYPASS_EN
    chk("x9_set_wins", b32.busy_vec[9], 1);
    chk("x9_pend", b32.pend_cnt, 1);
`else
    chk("x9_cleared", b32.busy_vec[9], 0);
    chk("x9_pend", b32.pend_cnt, 0);
`endif
    step(); b32.we_b = 1; b32.wa_b = 5'd9; b32.wd_b = 32'h9A;
    step(); idle32();

    // fill then drain the whole scoreboard
    for (int i = 1; i < 32; i++) begin
      step(); idle32(); b32.iss_req = 1; b32.iss_rd = 5'(i);
    end
    step(); idle32();
    #1;
    chk("fill_pend", b32.pend_cnt, 31);
    chk("fill_busy", b32.busy_vec, 32'hFFFF_FFFE);
    for (int i = 1; i < 32; i++) begin
      step(); idle32(); b32.we_b = 1; b32.wa_b = 5'(i); b32.wd_b = 32'h1000 + 32'(i * 3);
    end
    step(); idle32(); b32.ra1 = 5'd31;
    #1;
    chk("drain_pend", b32.pend_cnt, 0);
    chk("drain_x31", b32.rd1, 32'h105D);

    // mixed traffic, checked by the model only
    for (int i = 0; i < 40; i++) begin
      step();
      b32.iss_req = (i % 3) == 0; b32.iss_rd = 5'((i * 7) % 32);
      b32.ra1 = 5'((i * 5) % 32); b32.ra2 = 5'((i * 11) % 32);
      b32.we_a = i[0]; b32.wa_a = 5'((i * 3) % 32); b32.wd_a = 32'(i * 257);
      b32.we_b = (i % 4) == 1; b32.wa_b = 5'((i * 13) % 32); b32.wd_b = ~32'(i);
    end

    // reset in the middle of outstanding work, then a late writeback
    step(); idle32(); b32.iss_req = 1; b32.iss_rd = 5'd12;
    step(); b32.iss_rd = 5'd13;
    step(); idle32(); b32.iss_req = 1; b32.ra1 = 5'd12;
    #1 chk("pre_rst_stall", b32.stall, 1);
    areset = 0;
    #1;
    chk("mid_rst_busy", b32.busy_vec, 0);
    chk("mid_rst_stall", b32.stall, 0);
    step(); areset = 1; idle32();
    b32.we_b = 1; b32.wa_b = 5'd12; b32.wd_b = 32'hCAFE;
    step(); idle32(); b32.ra1 = 5'd12;
    #1;
    chk("late_wb_rd", b32.rd1, 32'hCAFE);
    chk("late_wb_pend", b32.pend_cnt, 0);

    // 16-register instance
    step(); b16.we_a = 1; b16.wa_a = 4'd15; b16.wd_a = 32'hA5A5A5A5;
    step(); idle16(); b16.ra1 = 4'd15;
    #1 chk("r16_x15", b16.rd1, 32'hA5A5A5A5);
    step(); idle16(); b16.ra1 = 4'd15; b16.iss_req = 1; b16.iss_rd = 4'd3;
    #1 chk("r16_iss_nostall", b16.stall, 0);
    step(); b16.iss_rd = 4'd0; b16.ra2 = 4'd3;
    #1;
    chk("r16_busy3", b16.busy_vec, 16'h0008);
    chk("r16_stall", b16.stall, 1);
    areset16 = 0;
    #1;
    chk("r16_rst_busy", b16.busy_vec, 0);
    chk("r16_rst_stall", b16.stall, 0);
    chk("r16_rst_x15", b16.rd1, 0);
    chk("r16_rst_pend", b16.pend_cnt, 0);
    step(); areset16 = 1; idle16();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the single-write-port integer register file.
- Adds a second write port, so the ALU and load/long-latency writebacks can retire in the same cycle.
- Adds a per-register busy scoreboard for outstanding long-latency writes, with a hazard/stall output to the issue stage.
- Width and register count are configurable, so RV32I (32 regs) and RV32E (16 regs) share one block.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, architectural register count (16 or 32); x0 is always included.
- AW, $clog2(NREGS), register address width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- areset  input  1  asynchronous, active-low reset.
- ra1  input  AW  read address, port 1 (rs1).
- ra2  input  AW  read address, port 2 (rs2).
- rd1  output  XLEN  read data, port 1.
- rd2  output  XLEN  read data, port 2.
- we_a  input  1  write enable, port A (ALU writeback).
- wa_a  input  AW  write address, port A.
- wd_a  input  XLEN  write data, port A.
- we_b  input  1  write enable, port B (load/long-latency writeback); also clears busy.
- wa_b  input  AW  write address, port B.
- wd_b  input  XLEN  write data, port B.
- iss_req  input  1  issue stage presents an instruction that will write via port B.
- iss_rd  input  AW  destination of the issuing instruction.
- stall  output  1  hazard detected; issue must hold.
- busy_vec  output  NREGS  scoreboard bits; bit 0 is always 0.
- pend_cnt  output  AW+1  number of busy registers.

Behaviour:
- Reset (areset=0, async):
  - registers 1..NREGS-1 cleared to 0.
  - busy_vec = 0, pend_cnt = 0.
  - stall = 0 while in reset.
- x0:
  - not stored.
  - reads of address 0 return 0.
  - writes to address 0 are dropped on both ports.
  - busy[0] is never set.
- Reads: combinational, zero latency.
- Writes:
  - commit on posedge when enabled.
  - we_a and we_b to the same non-zero address in one cycle: port A wins; port B data is discarded, but the busy clear from port B still happens.
- Address range: addresses >= NREGS (only when NREGS is not a power of two) read as 0; writes to them are ignored.
- Scoreboard:
  - set_hit = iss_req & ~stall & iss_rd != 0.
  - clr_hit = we_b & wa_b != 0.
  - On posedge: busy[iss_rd] set if set_hit; busy[wa_b] cleared if clr_hit.
  - Same register set and cleared in one cycle: set wins, bit stays 1, because the new owner is the younger instruction.
- pend_cnt:
  - registered.
  - +1 on a set of a non-busy bit, −1 on a clear of a busy bit, net 0 when both occur.
  - Saturation impossible, since the maximum is NREGS−1.
- stall:
  - combinational.
  - stall = iss_req & (eff_busy[ra1] | eff_busy[ra2] | eff_busy[iss_rd]), where the iss_rd term covers WAW.
  - eff_busy definition is set by the optional feature below.
- Interface rules:
  - ra1/ra2 are treated as the sources of the instruction presented with iss_req.
  - iss_req without stall is consumed in that cycle.
  - Issuing to an already-busy rd is prevented by the WAW term.
- Reset mid-operation: busy bits are cleared immediately, and late writebacks after reset are accepted as ordinary writes.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - Reads forward same-cycle write data: a port A match returns wd_a, else a port B match returns wd_b, else the stored value.
  - The address-0 rule still applies.
  - eff_busy[r] = busy[r] & ~(clr_hit & wa_b == r), so a writeback completing this cycle releases the stall in the same cycle.
- Undefined:
  - Reads return the pre-edge stored value.
  - eff_busy = busy, so stall persists through the writeback cycle and releases one cycle later.

Test Plan:
- Reset, then read every address, write x0 = 32'hDEADBEEF via both ports → all reads 0, busy_vec = 0, pend_cnt = 0.
- we_a: x5 = 32'h11, we_b: x5 = 32'h22 in the same cycle → next cycle rd1(ra1=5) = 32'h11.
- iss_req with iss_rd=7 → busy_vec[7]=1, pend_cnt=1; then iss_req with ra1=7 → stall=1.
  - we_b x7 = 32'h77: bypass build gives stall=0 and rd1 = 32'h77 in that cycle; non-bypass build releases stall next cycle.
- Same cycle iss_req rd=9 (not stalled) and we_b wa_b=9 while x9 is busy → busy[9] stays 1, pend_cnt unchanged.
- NREGS=16 build: write x15 = 32'hA5A5A5A5 and read it back; iss_req rd=3 then ra2=3 → stall=1; assert areset mid-stall → busy_vec=0, stall=0, x15=0.
- Fill scoreboard x1..x31 via iss_req (NREGS=32) → pend_cnt=31; drain with we_b → pend_cnt=0.
